// File: rtl/psd_scheduler_if.sv
// Requester bus plus detector link for the psd scheduler.
// master = requesters and detector side, slave = scheduler.
interface psd_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] pat;
  logic [NREQ-1:0]   din;
  logic [NREQ-1:0]   din_valid;
  logic [NREQ-1:0]   din_last;
  logic [NREQ-1:0]   gnt;
  logic              psd_resetn;
  logic [0:4]        psd_init;
  logic              psd_din;
  logic              psd_seen;
  logic [7:0]        hit_cnt;
  logic              done;
  logic              err;
  logic [1:0]        done_id;

  modport master (
    output req, pat, din, din_valid, din_last, psd_seen,
    input  gnt, psd_resetn, psd_init, psd_din, hit_cnt, done, err, done_id
  );

  modport slave (
    input  req, pat, din, din_valid, din_last, psd_seen,
    output gnt, psd_resetn, psd_init, psd_din, hit_cnt, done, err, done_id
  );
endinterface

// File: rtl/psd_scheduler.sv
// Round-robin scheduler time-sharing one programmable sequence detector
// among NREQ requesters; counts matches per session.
//
// state | meaning
// IDLE  | no owner, detector held in reset, arbitrating
// LOAD  | detector in reset with owner pattern, grant asserted
// RUN   | streaming owner bits into the detector
// DRAIN | last bit sent, sampling the final match flag
// FIN   | one-cycle done/err report, grant released
module psd_scheduler #(
  parameter int NREQ = 4
) (
  input logic           clk,
  input logic           reset,
  psd_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q;
  logic [1:0]  rr_q;
  logic [4:0]  pat_q;
  logic [7:0]  hit_q;
  logic        pend_q;
  logic        err_q;

  logic [1:0]  win;
  logic        found;
  logic [1:0]  idx;
  logic        abort;
  logic        accept;
  logic [4:0]  pat_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pat
    assign pat_arr[g] = bus.pat[5*g+4 : 5*g];
  end

  always_comb begin
    win   = rr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 2'((int'(rr_q) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE:  if (found) state_d = LOAD;
      LOAD: begin
        if (!bus.req[owner_q]) begin
          abort   = 1'b1;
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // detector has no enable, so any missing bit corrupts the stream
        if (!bus.req[owner_q] || !bus.din_valid[owner_q]) begin
          abort   = 1'b1;
          state_d = FIN;
        end else begin
          accept = 1'b1;
          if (bus.din_last[owner_q]) state_d = DRAIN;
        end
      end
      DRAIN: begin
        abort   = !bus.req[owner_q];
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt        = '0;
    bus.psd_resetn = 1'b0;
    bus.psd_din    = 1'b0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    case (state_q)
      LOAD:  bus.gnt[owner_q] = 1'b1;
      RUN: begin
        bus.gnt[owner_q] = 1'b1;
        bus.psd_resetn   = 1'b1;
        bus.psd_din      = bus.din[owner_q];
      end
      DRAIN: begin
        bus.gnt[owner_q] = 1'b1;
        bus.psd_resetn   = 1'b1;
      end
      FIN: begin
        bus.done = !err_q;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

  assign bus.psd_init = pat_q;
  assign bus.hit_cnt  = hit_q;
  assign bus.done_id  = owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      rr_q    <= 2'd0;
      pat_q   <= 5'd0;
      hit_q   <= 8'd0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= accept;
      if (state_q == IDLE && found) begin
        owner_q <= win;
        pat_q   <= pat_arr[win];
        hit_q   <= 8'd0;
        err_q   <= 1'b0;
      end else if (pend_q && bus.psd_seen && hit_q != 8'hFF) begin
        hit_q <= hit_q + 8'd1;
      end
      if (abort) err_q <= 1'b1;
      if (state_q == FIN)
        rr_q <= (owner_q == 2'(NREQ-1)) ? 2'd0 : owner_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_psd_scheduler.sv
// Self-checking bench for psd_scheduler with a behavioural sequence detector.
module tb_psd_scheduler;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psd_scheduler_if #(.NREQ(NREQ)) bus();
  psd_scheduler #(.NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));

  // detector: registered overlapping match on the last five bits
  logic [4:0] det_init, det_sh;
  logic [2:0] det_cnt;
  logic       det_seen;
  always @(posedge clk) begin
    if (!bus.psd_resetn) begin
      det_sh   <= 5'd0;
      det_cnt  <= 3'd0;
      det_seen <= 1'b0;
      det_init <= bus.psd_init;
    end else begin
      det_sh <= {det_sh[3:0], bus.psd_din};
      if (det_cnt != 3'd7) det_cnt <= det_cnt + 3'd1;
      det_seen <= (det_cnt >= 3'd4) && ({det_sh[3:0], bus.psd_din} == det_init);
    end
  end
  assign bus.psd_seen = det_seen;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] id;
    logic       done;
    logic [7:0] hit;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          id;
    logic [4:0]  pat;
    int          nbits;
    logic [31:0] bits;
    int          gap;
    logic        drop;
    logic        done;
    logic [7:0]  hit;
  } vec_t;
  vec_t vt[6];

  always @(negedge clk) begin
    if (reset === 1'b0 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (sb.size() == 0) begin
        check("unexpected_end_pulse", {30'd0, bus.done, bus.err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_id", bus.done_id, e.id);
        check("done", bus.done, e.done);
        check("err", bus.err, !e.done);
        check("hit_cnt", bus.hit_cnt, e.hit);
        check("fin_gnt", bus.gnt, 0);
        check("fin_psd_resetn", bus.psd_resetn, 0);
      end
    end
  end

  function automatic logic getbit(vec_t v, int k);
    if (v.nbits <= 32) return v.bits[v.nbits-1-k];
    return v.bits[k % 32];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, bus.gnt, 0);
    check({tag, "_psd_resetn"}, bus.psd_resetn, 0);
    check({tag, "_psd_init"}, bus.psd_init, 0);
    check({tag, "_psd_din"}, bus.psd_din, 0);
    check({tag, "_hit_cnt"}, bus.hit_cnt, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_done_id"}, bus.done_id, 0);
  endtask

  task automatic run_session(input vec_t v);
    int t;
    int cyc;
    int exp_lat;
    bus.pat[5*v.id +: 5] = v.pat;
    bus.req[v.id] = 1'b1;
    sb.push_back('{2'(v.id), v.done, v.hit});
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.gnt[v.id] !== 1'b1 && t < 200);
    check("grant_seen", bus.gnt[v.id], 1);
    if (bus.gnt[v.id] !== 1'b1) return;
    check("load_gnt_onehot", bus.gnt, 32'd1 << v.id);
    check("load_hit_clear", bus.hit_cnt, 0);
    check("load_psd_init", bus.psd_init, v.pat);
    check("load_psd_resetn", bus.psd_resetn, 0);
    cyc = 0;
    for (int k = 0; k < v.nbits; k++) begin
      @(negedge clk);
      cyc++;
      if (v.gap != 0 && k == v.gap - 1) begin
        if (v.drop) bus.req[v.id] = 1'b0;
        else        bus.din_valid[v.id] = 1'b0;
        break;
      end
      bus.din[v.id]       = getbit(v, k);
      bus.din_valid[v.id] = 1'b1;
      bus.din_last[v.id]  = (k == v.nbits - 1);
    end
    @(negedge clk);
    cyc++;
    bus.din_valid[v.id] = 1'b0;
    bus.din_last[v.id]  = 1'b0;
    while (bus.done !== 1'b1 && bus.err !== 1'b1 && cyc < v.nbits + 10) begin
      @(negedge clk);
      cyc++;
    end
    exp_lat = (v.gap != 0) ? v.gap + 1 : v.nbits + 2;
    check("fin_latency", cyc, exp_lat);
    bus.req[v.id]       = 1'b0;
    bus.din_valid[v.id] = 1'b0;
    bus.din_last[v.id]  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t pa, pb;
    vt[0] = '{0, 5'b11011, 8,   32'b11011011,   0, 1'b0, 1'b1, 8'd2};
    vt[1] = '{2, 5'b11111, 5,   32'b11111,      3, 1'b0, 1'b0, 8'd0};
    vt[2] = '{0, 5'b11111, 300, 32'hFFFFFFFF,   0, 1'b0, 1'b1, 8'd255};
    vt[3] = '{1, 5'b10000, 1,   32'b1,          0, 1'b0, 1'b1, 8'd0};
    vt[4] = '{3, 5'b00000, 6,   32'b000000,     0, 1'b0, 1'b1, 8'd2};
    vt[5] = '{1, 5'b10101, 10,  32'b1010101010, 8, 1'b1, 1'b0, 8'd2};

    reset         = 1'b1;
    bus.req       = '0;
    bus.pat       = '0;
    bus.din       = '0;
    bus.din_valid = '0;
    bus.din_last  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // simultaneous requests after reset: lowest index wins first
    pa = '{1, 5'b10101, 5, 32'b10101, 0, 1'b0, 1'b1, 8'd1};
    pb = '{3, 5'b10101, 5, 32'b10101, 0, 1'b0, 1'b1, 8'd1};
    bus.pat[5*1 +: 5] = pa.pat;
    bus.pat[5*3 +: 5] = pb.pat;
    bus.req[1] = 1'b1;
    bus.req[3] = 1'b1;
    run_session(pa);
    run_session(pb);

    for (int i = 0; i < 6; i++) run_session(vt[i]);

    // last owner was 1, so the pointer sits at 2 and req3 beats req0
    pa = '{3, 5'b01100, 7, 32'b1011001, 0, 1'b0, 1'b1, 8'd1};
    pb = '{0, 5'b11011, 8, 32'b11011011, 0, 1'b0, 1'b1, 8'd2};
    bus.pat[5*3 +: 5] = pa.pat;
    bus.pat[5*0 +: 5] = pb.pat;
    bus.req[3] = 1'b1;
    bus.req[0] = 1'b1;
    run_session(pa);
    run_session(pb);

    // reset in the middle of a run kills the session with no report
    bus.pat[4:0]    = 5'b11111;
    bus.din[0]      = 1'b1;
    bus.din_valid[0] = 1'b1;
    bus.din_last[0] = 1'b0;
    bus.req[0]      = 1'b1;
    begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (bus.gnt[0] !== 1'b1 && t < 50);
      check("pre_reset_grant", bus.gnt[0], 1);
    end
    repeat (5) @(negedge clk);
    check("pre_reset_running", bus.psd_resetn, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    reset = 1'b0;
    pa = '{0, 5'b11111, 5, 32'b11111, 0, 1'b0, 1'b1, 8'd1};
    run_session(pa);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
